// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
//   Consumer side of the hazard/freeze interface. Takes the combinational
//   load-use freeze request, the EX-stage branch resolution and the external
//   interrupt, and drives the PC enable, IF/ID enable/flush, ID/EX bubble and
//   interrupt-vector select. Multi-cycle stalls, flushes and interrupt entry
//   are sequenced by a small FSM with a 3-bit down counter.
//
// Parameters
//   STALL_CYCLES  bubbles inserted per load-use hazard (1..7)
//   FLUSH_CYCLES  cycles IF/ID + ID/EX are flushed after a taken branch (1..7)
//   INT_CYCLES    interrupt entry length in cycles (2..7)
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous reset, active-high
//   hazard_req    load-use freeze request (same cycle)
//   branch_taken  taken branch/jump resolved in EX this cycle
//   int_req       external interrupt level, rising edge = new request
//   pc_en         PC register load enable
//   ifid_en       IF/ID register load enable
//   ifid_flush    IF/ID register clear
//   idex_bubble   ID/EX register loads NOP control word
//   int_ack       one-cycle pulse on the first INT cycle
//   int_vec_sel   PC mux selects interrupt vector (last INT cycle)
//   stall_count   cycles with pc_en low (optional counter)
//
// Build option
//   STALL_PERF_CNT_EN  when defined, stall_count is a saturating 16-bit count of
//                      cycles with pc_en low, cleared only by rst. Otherwise it
//                      is tied to zero and no counter flops exist.
//
// state | meaning
// RUN   | normal flow; branch/hazard/interrupt decisions are made here
// STALL | load-use freeze continues; PC and IF/ID hold, ID/EX bubbles
// FLUSH | post-branch flush continues; IF/ID and ID/EX cleared
// INT   | interrupt entry; first cycle acks, last cycle loads the vector

module pipeline_stall_controller #(
   parameter int STALL_CYCLES = 1,
   parameter int FLUSH_CYCLES = 1,
   parameter int INT_CYCLES   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hazard_req,
   input  logic        branch_taken,
   input  logic        int_req,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        ifid_flush,
   output logic        idex_bubble,
   output logic        int_ack,
   output logic        int_vec_sel,
   output logic [15:0] stall_count
);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_STALL = 2'd1,
      S_FLUSH = 2'd2,
      S_INT   = 2'd3
   } state_t;

   localparam logic [2:0] STALL_LOAD = 3'(STALL_CYCLES - 1);
   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
   localparam logic [2:0] INT_LOAD   = 3'(INT_CYCLES - 1);

   state_t     state;
   state_t     state_nxt;
   logic [2:0] cnt;
   logic [2:0] cnt_nxt;
   logic       int_pending;
   logic       int_req_q;
   logic       int_rise;
   logic       int_enter;

   assign int_rise = int_req & ~int_req_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_RUN;
         cnt         <= 3'd0;
         int_pending <= 1'b0;
         int_req_q   <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         int_req_q   <= int_req;
         // an edge arriving in the same cycle as entry stays pending for a
         // later entry instead of being swallowed by the clear
         int_pending <= (int_pending & ~int_enter) | int_rise;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      int_enter   = 1'b0;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      int_ack     = 1'b0;
      int_vec_sel = 1'b0;

      if (rst) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else begin
         unique case (state)
            S_RUN: begin
               pc_en   = 1'b1;
               ifid_en = 1'b1;
               if (branch_taken) begin
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     state_nxt = S_FLUSH;
                     cnt_nxt   = FLUSH_LOAD;
                  end
               end else if (hazard_req) begin
                  pc_en       = 1'b0;
                  ifid_en     = 1'b0;
                  idex_bubble = 1'b1;
                  if (STALL_CYCLES > 1) begin
                     state_nxt = S_STALL;
                     cnt_nxt   = STALL_LOAD;
                  end
               end else if (int_pending) begin
                  state_nxt = S_INT;
                  cnt_nxt   = INT_LOAD;
                  int_enter = 1'b1;
               end
            end

            S_STALL: begin
               if (branch_taken) begin
                  pc_en       = 1'b1;
                  ifid_en     = 1'b1;
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     state_nxt = S_FLUSH;
                     cnt_nxt   = FLUSH_LOAD;
                  end else begin
                     state_nxt = S_RUN;
                     cnt_nxt   = 3'd0;
                  end
               end else begin
                  idex_bubble = 1'b1;
                  cnt_nxt     = cnt - 3'd1;
                  if (cnt == 3'd1) state_nxt = S_RUN;
               end
            end

            S_FLUSH: begin
               pc_en       = 1'b1;
               ifid_en     = 1'b1;
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               if (branch_taken) begin
                  cnt_nxt = FLUSH_LOAD;
                  if (FLUSH_CYCLES <= 1) state_nxt = S_RUN;
               end else begin
                  cnt_nxt = cnt - 3'd1;
                  if (cnt == 3'd1) state_nxt = S_RUN;
               end
            end

            S_INT: begin
               // INT occupies INT_CYCLES cycles: cnt runs INT_LOAD..0, so the
               // first cycle is cnt==INT_LOAD and the vector cycle is cnt==0
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               int_ack     = (cnt == INT_LOAD);
               if (cnt == 3'd0) begin
                  pc_en       = 1'b1;
                  int_vec_sel = 1'b1;
                  state_nxt   = S_RUN;
               end else begin
                  cnt_nxt = cnt - 3'd1;
               end
            end

            default: begin
               state_nxt = S_RUN;
               cnt_nxt   = 3'd0;
            end
         endcase
      end
   end

`ifdef STALL_PERF_CNT_EN
   logic [15:0] perf_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_cnt <= 16'h0000;
      end else if (!pc_en && (perf_cnt != 16'hFFFF)) begin
         perf_cnt <= perf_cnt + 16'h0001;
      end
   end

   assign stall_count = perf_cnt;
`else
   assign stall_count = 16'h0000;
`endif

endmodule
